// File: rtl/wb_stage.sv
// wb_stage: write-back register; drives the regfile write port, the ID forwarding bus and a retire counter.
// Latency: 1 cycle (captured at edge N, visible in cycle N+1); all outputs come from WB state only.
// Backpressure: wb_allowin = ~stall & ~flush; a held entry writes the regfile exactly once.
// Optional trace port (debug_wb_*) is present only when WB_DEBUG_TRACE_EN is defined.
module wb_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_to_wb_valid,
   input  logic [69:0] mem_to_wb_bus,
   output logic        wb_allowin,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [37:0] wb_to_id_bus,
   output logic [31:0] retire_cnt
`ifdef WB_DEBUG_TRACE_EN
   ,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
`endif
);

   logic        r_wb_valid;
   logic        r_wb_done;
   logic [69:0] r_wb_bus;
   logic [31:0] r_retire_cnt;

   logic [31:0] w_bus_pc;
   logic        w_bus_we;
   logic [4:0]  w_bus_waddr;
   logic [31:0] w_bus_wdata;
   logic        w_capture;
   logic        w_wb_fire;
   logic        w_dest_ok;

   assign w_bus_pc    = r_wb_bus[69:38];
   assign w_bus_we    = r_wb_bus[37];
   assign w_bus_waddr = r_wb_bus[36:32];
   assign w_bus_wdata = r_wb_bus[31:0];

   assign wb_allowin  = ~stall & ~flush;
   assign w_capture   = mem_to_wb_valid & wb_allowin;
   // The entry commits only on its first valid cycle; later held cycles are silent.
   assign w_wb_fire   = r_wb_valid & ~r_wb_done;
   // Writes to $0 never reach the regfile or the forwarding bus.
   assign w_dest_ok   = w_bus_we & (w_bus_waddr != 5'd0);

   assign rf_we        = w_wb_fire & w_dest_ok;
   assign rf_waddr     = w_bus_waddr;
   assign rf_wdata     = w_bus_wdata;
   // Forwarding stays asserted for as long as the entry is held, not only on the fire cycle.
   assign wb_to_id_bus = {r_wb_valid & w_dest_ok, w_bus_waddr, w_bus_wdata};
   assign retire_cnt   = r_retire_cnt;

   // Pipeline entry: flush drops it, capture loads it, otherwise drain or hold and mark committed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wb_valid <= 1'b0;
         r_wb_done  <= 1'b0;
         r_wb_bus   <= 70'd0;
      end else if (flush) begin
         r_wb_valid <= 1'b0;
         r_wb_done  <= 1'b0;
      end else if (w_capture) begin
         r_wb_bus   <= mem_to_wb_bus;
         r_wb_valid <= 1'b1;
         r_wb_done  <= 1'b0;
      end else begin
         if (wb_allowin) begin
            r_wb_valid <= 1'b0;
         end
         if (w_wb_fire) begin
            r_wb_done <= 1'b1;
         end
      end
   end

   // Retired-instruction count: one per commit, including non-writing ones and a fire under flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_retire_cnt <= 32'd0;
      end else if (w_wb_fire) begin
         r_retire_cnt <= r_retire_cnt + 32'd1;
      end
   end

`ifdef WB_DEBUG_TRACE_EN
   assign debug_wb_pc       = w_bus_pc;
   assign debug_wb_rf_wen   = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;
`else
   // The pc field is only observable through the trace port.
   logic w_unused_pc;
   assign w_unused_pc = ^w_bus_pc;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage pipeline. It registers the MEM-stage result and drives the register file's single write port (`we`/`waddr`/`wdata`). It also returns the same write to ID as a forwarding bus, and keeps a retired-instruction counter. Each instruction writes the register file exactly once, even while WB is held by a stall.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold WB contents; no new capture while high.
- `flush`  in  1  discard the WB entry (exception/eret redirect).
- `mem_to_wb_valid`  in  1  MEM presents a valid instruction.
- `mem_to_wb_bus`  in  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- `wb_allowin`  out  1  WB accepts `mem_to_wb_bus` at the next edge.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `wb_to_id_bus`  out  38  {we[37], waddr[36:32], wdata[31:0]}; forwarding to ID.
- `retire_cnt`  out  32  instructions retired since reset.
- `debug_wb_pc`, `debug_wb_rf_wen[3:0]`, `debug_wb_rf_wnum[4:0]`, `debug_wb_rf_wdata[31:0]`  out  trace port; present only with `WB_DEBUG_TRACE_EN`.

## Operation
- State:
  - `wb_valid`
  - `wb_done`: this entry has already committed.
  - `wb_bus_r[69:0]`
  - `retire_cnt[31:0]`
- `wb_allowin = ~stall & ~flush`.
- Capture happens when `mem_to_wb_valid & wb_allowin`:
  - `wb_bus_r <= mem_to_wb_bus`, `wb_valid <= 1`, `wb_done <= 0`.
- If there is no capture and `wb_allowin` is high, then `wb_valid <= 0`.
- `flush` takes priority over everything: it sets `wb_valid <= 0` and `wb_done <= 0` at the edge, and nothing is captured.
- `wb_fire = wb_valid & ~wb_done`. On `wb_fire`, `wb_done <= 1`. The entry commits once, even if `stall` holds it for many cycles.
- `rf_we = wb_fire & bus_we & (bus_waddr != 0)`. Writes to $0 are suppressed at the port.
- `rf_waddr` and `rf_wdata` come straight from `wb_bus_r`. Their value is don't-care when `rf_we = 0`.
- `wb_to_id_bus = {wb_valid & bus_we & (bus_waddr != 0), bus_waddr, bus_wdata}`:
  - Stays asserted for the whole time the entry is held, not just the fire cycle.
  - ID must give EX and MEM priority over this bus.
- `retire_cnt` increments by 1 on every `wb_fire`, whether or not the instruction writes a register. It wraps from 0xFFFFFFFF to 0. A flush never decrements it.
- `flush` asserted in the same cycle as `wb_fire`: the write still happens and the count still increments in that cycle. The entry is dropped at the edge.

## Timing
- Latency is one cycle: data captured at edge N drives `rf_we`/`wb_to_id_bus` during cycle N+1. The regfile is written at edge N+1.
- Output is combinational from WB state only. There is no path from `mem_to_wb_bus` to `rf_*` within the same cycle.
- Back-to-back instructions each fire in consecutive cycles, giving a sustained rate of 1 per cycle.
- While `stall` is high, the entry is held, `rf_we` is high only on the first held cycle, and `wb_to_id_bus` is steady.
- Reset (asynchronous assert, synchronous release):
  - `wb_valid = 0`, `wb_done = 0`, `wb_bus_r = 0`, `retire_cnt = 0`.
  - Therefore `rf_we = 0`, `wb_to_id_bus = 0`, and all debug outputs are 0.
- Reset mid-stall discards the held entry immediately.

## Configuration
- `WB_DEBUG_TRACE_EN` defined:
  - `debug_wb_pc = bus_pc`.
  - `debug_wb_rf_wen = {4{rf_we}}`.
  - `debug_wb_rf_wnum = rf_waddr`.
  - `debug_wb_rf_wdata = rf_wdata`.
  - This matches the golden-trace comparator; it pulses once per write.
- Undefined: the four debug ports are removed and the register-file behaviour is unchanged.

## Test plan
- Reset with `resetn = 0` for 3 cycles while `mem_to_wb_valid = 1` → `rf_we = 0`, `retire_cnt = 0`, `wb_to_id_bus = 0` throughout.
- Single write: pc = 0xBFC00000, we = 1, waddr = 8, wdata = 0x12345678, valid one cycle → next cycle `rf_we = 1`, `rf_waddr = 8`, `rf_wdata = 0x12345678`; `retire_cnt` goes 0→1; trace wen = 4'hF.
- $0 write: waddr = 0, we = 1 → `rf_we = 0` and `wb_to_id_bus[37] = 0`, but `retire_cnt` still increments.
- Stall hold: capture waddr = 5, then `stall = 1` for 4 cycles → `rf_we` high for 1 cycle only; `wb_to_id_bus` = {1, 5, data} for all 5 cycles; `retire_cnt` +1; `wb_allowin = 0` during the stall.
- Flush: capture an entry, assert `flush` in its fire cycle → write occurs once; next cycle `wb_valid = 0` and the MEM input offered that cycle is not captured.
- Wrap: preload `retire_cnt` to 0xFFFFFFFE by force, retire 3 instructions → count reads 0xFFFFFFFF, 0x00000000, 0x00000001.
